// File: rtl/noise_pkg.sv
// Shared constants for the LFSR noise source.
//  - MODE_LONG / MODE_SHORT select the active register width.
//  - DEF_* hold the default long-mode geometry, taps and reset seed.
//  - lane_seed() derives a lane's seed by rotating a base value left by 3*lane.
package noise_pkg;

  localparam logic MODE_LONG  = 1'b0;
  localparam logic MODE_SHORT = 1'b1;

  localparam int DEF_LFSR_W   = 31;
  localparam int DEF_TAP      = 27;  // x^31 + x^28 + 1
  localparam int DEF_SHORT_W  = 7;
  localparam int SHORT_TAP_HI = 6;   // x^7 + x^6 + 1, period 127
  localparam int SHORT_TAP_LO = 5;
  localparam int ROT_STEP     = 3;

  localparam logic [DEF_LFSR_W-1:0] DEF_SEED_BASE = 31'h1A926572;

  // Rotate the low w bits of base left by ROT_STEP*lane (w must be < 64).
  // Bits of base above w are expected to be zero.
  function automatic logic [63:0] lane_seed(input logic [63:0] base,
                                            input int         w,
                                            input int         lane);
    logic [63:0] mask;
    int          s;
    mask = (64'd1 << w) - 64'd1;
    s    = (ROT_STEP * lane) % w;
    return ((base << s) | (base >> (w - s))) & mask;
  endfunction

endpackage

// File: rtl/lfsr_lane.sv
// One Fibonacci LFSR lane.
//  Ports:
//   clk, rst_n  clock / asynchronous active-low reset (state -> RST_SEED)
//   load        load load_val (guarded), wins over step
//   load_val    seed for this lane, already rotated by the parent
//   step        advance the register one shift
//   mode        MODE_LONG: full LFSR_W register; MODE_SHORT: low SHORT_W bits only
//   state       current register contents
module lfsr_lane
  import noise_pkg::*;
#(
  parameter int                LFSR_W   = DEF_LFSR_W,
  parameter int                TAP      = DEF_TAP,
  parameter int                SHORT_W  = DEF_SHORT_W,
  parameter int                S_TAP_A  = SHORT_TAP_HI,
  parameter int                S_TAP_B  = SHORT_TAP_LO,
  parameter logic [LFSR_W-1:0] RST_SEED = DEF_SEED_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  input  logic              mode,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_reg;
  logic [LFSR_W-1:0] state_next;
  logic [LFSR_W-1:0] shift_long;
  logic [LFSR_W-1:0] shift_short;
  logic [LFSR_W-1:0] raw_next;

  assign shift_long  = {state_reg[LFSR_W-2:0], state_reg[LFSR_W-1] ^ state_reg[TAP]};
  // Short mode only rotates the low window; the upper bits are parked untouched
  // so switching back to long mode resumes with them intact.
  assign shift_short = {state_reg[LFSR_W-1:SHORT_W],
                        state_reg[SHORT_W-2:0],
                        state_reg[S_TAP_A] ^ state_reg[S_TAP_B]};

  // The zero guard runs on every update in the currently active width. A
  // well-formed LFSR never shifts into zero, so in steady state it only fires
  // on a zero seed or on the first short-mode shift after a mode change that
  // left the low window empty.
  always_comb begin
    raw_next   = load ? load_val : ((mode == MODE_SHORT) ? shift_short : shift_long);
    state_next = raw_next;
    if (mode == MODE_LONG && raw_next == '0)
      state_next = LFSR_W'(1);
    if (mode == MODE_SHORT && raw_next[SHORT_W-1:0] == '0)
      state_next[SHORT_W-1:0] = SHORT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= RST_SEED;
    else if (load || step)
      state_reg <= state_next;
  end

  assign state = state_reg;

endmodule

// File: rtl/lfsr_noise_gen.sv
// Multi-lane LFSR noise source feeding the voice mixer noise input.
//  Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   en          1 = run; 0 = freeze rate counter, lanes and output
//   rate_div    one tick every rate_div+1 enabled cycles
//   mode        0 = long LFSR_W-bit lanes, 1 = short SHORT_W-bit lanes
//   seed_load   single-cycle pulse: reseed all lanes (accepted with en = 0)
//   seed        base seed; lane i receives seed rotated left by 3*i
//   sout        noise word, lane 0 on the MSB
//   sout_valid  single-cycle strobe when sout updates
//  OUT_BIT must stay below SHORT_W so short mode still produces noise.
module lfsr_noise_gen
  import noise_pkg::*;
#(
  parameter int                LANES     = 8,
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter int                TAP       = DEF_TAP,
  parameter int                SHORT_W   = DEF_SHORT_W,
  parameter int                OUT_BIT   = 5,
  parameter int                DIV_W     = 16,
  parameter logic [LFSR_W-1:0] SEED_BASE = DEF_SEED_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [LANES-1:0]  sout,
  output logic              sout_valid
);

  logic [DIV_W-1:0] cnt_reg;
  logic [LANES-1:0] sout_reg;
  logic             valid_reg;
  logic             tick;
  logic [LANES-1:0] sample;

  // ">=" rather than "==" so that lowering rate_div below the running count
  // produces a tick on the next enabled cycle instead of a counter wrap.
  // A seed load suppresses the tick so the lanes load instead of shifting.
  assign tick = en && !seed_load && (cnt_reg >= rate_div);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [LFSR_W-1:0] LANE_SEED =
      LFSR_W'(lane_seed(64'(SEED_BASE), LFSR_W, gi));

    logic [LFSR_W-1:0] load_val;
    logic [LFSR_W-1:0] lane_state;

    assign load_val = LFSR_W'(lane_seed(64'(seed), LFSR_W, gi));

    lfsr_lane #(
      .LFSR_W   (LFSR_W),
      .TAP      (TAP),
      .SHORT_W  (SHORT_W),
      .RST_SEED (LANE_SEED)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_load),
      .load_val (load_val),
      .step     (tick),
      .mode     (mode),
      .state    (lane_state)
    );

    // Sampled from the pre-shift state, so sout lags the lanes by one shift.
    assign sample[LANES-1-gi] = lane_state[OUT_BIT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      sout_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= tick;
      if (seed_load)
        cnt_reg <= '0;
      else if (en)
        cnt_reg <= (cnt_reg >= rate_div) ? '0 : cnt_reg + DIV_W'(1);
      if (tick)
        sout_reg <= sample;
    end
  end

  assign sout       = sout_reg;
  assign sout_valid = valid_reg;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
module tb_lfsr_noise_gen;

  localparam int          LANES     = 8;
  localparam logic [30:0] SEED_BASE = 31'h1A926572;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rate_div = '0;
  logic        mode = 1'b0;
  logic        seed_load = 1'b0;
  logic [30:0] seed = '0;
  logic [7:0]  sout;
  logic        sout_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_noise_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rate_div   (rate_div),
    .mode       (mode),
    .seed_load  (seed_load),
    .seed       (seed),
    .sout       (sout),
    .sout_valid (sout_valid)
  );

  // ---------------- reference model (integer arithmetic on lane values) ----
  longint unsigned m_lane [LANES];
  longint unsigned m_cnt;
  logic [7:0]      m_sout;
  logic            m_valid;

  function automatic longint unsigned rotl31(input longint unsigned x, input int a);
    longint unsigned s;
    s = longint'(a % 31);
    return ((x << s) | (x >> (31 - s))) % 64'h8000_0000;
  endfunction

  // Active window must never be zero: long = whole value, short = value mod 128.
  function automatic longint unsigned guard(input longint unsigned v, input logic md);
    if (!md) return (v == 0) ? 64'd1 : v;
    return (v % 128 == 0) ? v + 1 : v;
  endfunction

  function automatic longint unsigned advance(input longint unsigned v, input logic md);
    longint unsigned lo, fb, r;
    if (!md) begin
      fb = ((v / 64'h4000_0000) + (v / 64'h0800_0000)) % 2;  // bit30 xor bit27
      r  = (v * 2) % 64'h8000_0000 + fb;
    end else begin
      lo = v % 128;
      fb = ((lo / 64) + (lo / 32)) % 2;                        // bit6 xor bit5
      r  = v - lo + ((lo * 2) % 128 + fb);
    end
    return guard(r, md);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) m_lane[i] = rotl31(64'(SEED_BASE), 3 * i);
    m_cnt = 0; m_sout = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    m_valid = 1'b0;
    if (seed_load) begin
      for (int i = 0; i < LANES; i++) m_lane[i] = guard(rotl31(64'(seed), 3 * i), mode);
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt >= 64'(rate_div)) begin
        for (int i = 0; i < LANES; i++) begin
          m_sout[LANES-1-i] = ((m_lane[i] / 32) % 2) == 1;
          m_lane[i] = advance(m_lane[i], mode);
        end
        m_cnt = 0; m_valid = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // ---------------- checking helpers ---------------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, DUT outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    chk("sout_model", 64'(sout), 64'(m_sout));
    chk("valid_model", 64'(sout_valid), 64'(m_valid));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sout_valid && n < 200);
    if (!sout_valid) chk("pulse_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_load(input logic [30:0] s, input logic md, input logic [15:0] rd);
    seed = s; mode = md; rate_div = rd; en = 1'b1; seed_load = 1'b1;
    cycle();
    chk("load_no_valid", 64'(sout_valid), 64'd0);
    seed_load = 1'b0;
  endtask

  // ---------------- directed table -----------------------------------------
  typedef struct {
    logic [30:0]     seed;
    logic            md;
    logic [15:0]     rd;
    logic [5:0][7:0] exp;   // exp[0] = pulse 1 ... exp[5] = pulse 6
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, nz;

    // {pulse6, pulse5, pulse4, pulse3, pulse2, pulse1}
    vecs[0] = '{31'd1,  1'b0, 16'd0, {8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00}};
    vecs[1] = '{31'd1,  1'b0, 16'd2, {8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00}};
    vecs[2] = '{31'd0,  1'b0, 16'd0, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[3] = '{31'd32, 1'b0, 16'd1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};
    vecs[4] = '{31'd1,  1'b1, 16'd0, {8'h9F, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00}};
    vecs[5] = '{31'd0,  1'b1, 16'd0, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

    // ---- reset and startup from default seeds
    model_reset();
    #1;
    chk("reset_sout", 64'(sout), 64'd0);
    chk("reset_valid", 64'(sout_valid), 64'd0);
    cycle(); cycle();
    rst_n = 1'b1; en = 1'b1; rate_div = 16'd0;
    for (int c = 0; c < 20; c++) cycle();
    $display("startup from default seeds: sout=%h", sout);

    // ---- asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("async_rst_sout", 64'(sout), 64'd0);
    chk("async_rst_valid", 64'(sout_valid), 64'd0);
    model_reset();
    cycle(); cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) cycle();
    $display("mid-run reset released: sout=%h", sout);

    // ---- table: seed, mode, divider -> first six output words
    for (int r = 0; r < 6; r++) begin
      do_load(vecs[r].seed, vecs[r].md, vecs[r].rd);
      for (int p = 0; p < 6; p++) begin
        wait_valid(n);
        chk($sformatf("row%0d_pulse%0d", r, p + 1), 64'(sout), 64'(vecs[r].exp[p]));
        chk($sformatf("row%0d_spacing", r), 64'(n), 64'(vecs[r].rd) + 1);
      end
      $display("row %0d seed=%h mode=%0d rate_div=%0d last sout=%h",
               r, vecs[r].seed, vecs[r].md, vecs[r].rd, sout);
    end

    // ---- rate divider: every 4th cycle, then lower rate_div while cnt = 2
    do_load(31'h1234567, 1'b0, 16'd3);
    for (int c = 1; c <= 12; c++) begin
      cycle();
      chk($sformatf("rate3_cycle%0d", c), 64'(sout_valid), 64'((c % 4) == 0));
    end
    cycle(); cycle();
    rate_div = 16'd0;
    cycle();
    chk("rate_lowered_tick", 64'(sout_valid), 64'd1);
    $display("rate divider sequence done");

    // ---- short mode period 127 on lane 0
    do_load(31'd1, 1'b1, 16'd0);
    for (int p = 1; p <= 140; p++) begin
      wait_valid(n);
      if (p == 1)   chk("short_p1",   64'(sout[7]), 64'd0);
      if (p == 6)   chk("short_p6",   64'(sout[7]), 64'd1);
      if (p == 128) chk("short_p128", 64'(sout[7]), 64'd0);
      if (p == 133) chk("short_p133", 64'(sout[7]), 64'd1);
    end
    $display("short mode 140 ticks done");

    // ---- zero seed: output must keep moving
    do_load(31'd0, 1'b0, 16'd0);
    nz = 0;
    for (int p = 0; p < 64; p++) begin
      wait_valid(n);
      if (sout != 8'h00) nz++;
    end
    chk("zero_guard_alive", 64'(nz != 0), 64'd1);
    $display("zero seed run: %0d nonzero words", nz);

    // ---- en freeze with counter mid-count, seed load while disabled
    do_load(31'h0ABCDEF, 1'b0, 16'd3);
    cycle(); cycle();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("freeze_valid", 64'(sout_valid), 64'd0);
    end
    en = 1'b1;
    cycle();
    chk("resume_cnt3", 64'(sout_valid), 64'd0);
    cycle();
    chk("resume_tick", 64'(sout_valid), 64'd1);
    en = 1'b0; seed = 31'd32; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0; en = 1'b1; rate_div = 16'd0;
    cycle();
    chk("load_while_disabled", 64'(sout), 64'h80);
    seed_load = 1'b1;   // coincides with a rate_div = 0 tick
    cycle();
    chk("load_beats_tick", 64'(sout_valid), 64'd0);
    seed_load = 1'b0;
    $display("enable / priority sequence done");

    // ---- randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 999) != 0);
      en        = ($urandom_range(0, 9) != 0);
      seed_load = ($urandom_range(0, 49) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 31'd0 : 31'($urandom);
      if ($urandom_range(0, 29) == 0) rate_div = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      cycle();
    end
    rst_n = 1'b1;
    $display("random run done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
